timing_menu_controller: RTL and testbench
=========================================

Name: timing_menu_controller

Overview:
Button-driven configuration front end that produces the green_duration, yellow_duration and red_holding values (seconds, 8-bit) consumed by the traffic light FSM. It debounces four raw push-buttons and runs a browse/edit menu. Edits are held in a shadow register and published atomically on confirm. It also drives display-facing status (selected field, edit value, edit flag).

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced button level changes (10 ms at 100 MHz)
TIMEOUT_CYCLES, 32'd1_000_000_000, idle cycles in EDIT before an automatic cancel (10 s)
GREEN_RST, 8'd5, reset value of green_duration
YELLOW_RST, 8'd2, reset value of yellow_duration
RED_RST, 8'd1, reset value of red_holding
GREEN_MIN / GREEN_MAX, 1 / 99, green limits
YELLOW_MIN / YELLOW_MAX, 1 / 9, yellow limits
RED_MIN / RED_MAX, 0 / 9, red-holding limits

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_up  in  1  raw button, increment (asynchronous to clk)
btn_down  in  1  raw button, decrement
btn_next  in  1  raw button, next field (BROWSE) / cancel (EDIT)
btn_select  in  1  raw button, enter edit (BROWSE) / commit (EDIT)
green_duration  out  8  committed green time, seconds
yellow_duration  out  8  committed yellow time, seconds
red_holding  out  8  committed all-red time, seconds
menu_index  out  2  selected field: 0=green, 1=yellow, 2=red (3 never driven)
edit_active  out  1  high while in EDIT
edit_value  out  8  shadow value in EDIT; committed value of the selected field in BROWSE
config_changed  out  1  one-cycle pulse on commit

Behaviour:
- Reset is asynchronous and active-low. It does not depend on the clock.
- Reset values: green/yellow/red outputs = GREEN_RST/YELLOW_RST/RED_RST; menu_index=0; edit_active=0; config_changed=0; shadow=0; state=BROWSE; all debounce state cleared (debounced levels=0).
- Per button, input conditioning:
  - 2-FF synchronizer.
  - Counter counts consecutive cycles where the synced value differs from the debounced level; any agreement clears the counter.
  - At DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips.
  - A 0->1 flip produces a 1-cycle press pulse in the same cycle. Releases produce no pulse.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Press latency: a raw edge held stable yields the press pulse DEBOUNCE_CYCLES+2 cycles after the edge is sampled.
- Simultaneous pulses are arbitrated select > next > up > down. Only the winner is acted on; the others are dropped.
- FSM, BROWSE:
  - next: menu_index 0->1->2->0.
  - select: shadow <= committed value of the selected field; go to EDIT; edit_active=1 from the next cycle.
  - up/down: ignored.
- FSM, EDIT:
  - up: shadow+1, saturating at the field MAX.
  - down: shadow-1, saturating at the field MIN. Never wraps; no underflow at 0 for the red field.
  - select (commit): the selected output <= shadow; config_changed=1 for 1 cycle; go to BROWSE. The output is visible the cycle after the pulse is accepted.
  - next (cancel): discard shadow; go to BROWSE; outputs are unchanged and no config_changed pulse is issued.
  - menu_index is frozen in EDIT.
- Edit timeout:
  - An idle counter runs only in EDIT and clears on any accepted pulse.
  - At TIMEOUT_CYCLES it performs a cancel. If a pulse is accepted in that same cycle, the pulse wins.
- Commits only touch one field; the other two outputs are held. All outputs are registered and glitch-free.
- Reset asserted mid-edit: shadow is discarded, outputs return to the reset values, state returns to BROWSE.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - In EDIT, holding up or down (debounced level high) emits repeat steps: the first at REPEAT_DELAY cycles after the press pulse (local param, 50_000_000), then every REPEAT_RATE cycles (10_000_000).
  - Repeat steps obey the same saturation and arbitration rules.
  - Repeating stops on release, on a state change, or if both up and down are held.
- Not defined: only press pulses change the shadow; no repeat logic is synthesized.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, default limits and reset values.
1. Release rst_n, no buttons -> outputs 5/2/1, menu_index=0, edit_active=0, config_changed=0; rst_n low mid-edit -> same values asynchronously.
2. Bounce btn_up 1-0-1 at 2-cycle intervals, then hold high -> exactly one press pulse, 6 cycles after the last rising edge is sampled; no pulse on release.
3. BROWSE: select, up x3, select -> green_duration=8, one config_changed pulse, edit_active=0; yellow and red unchanged at 2/1.
4. next x2 (menu_index=2), select, down x3 -> edit_value saturates 1->0->0->0; next -> red_holding stays 1, no config_changed.
5. Yellow field: select, up x10 -> edit_value=9 (YELLOW_MAX); idle 100 cycles -> auto-cancel, edit_active=0, yellow_duration=2.
6. next and select pulses in the same cycle in BROWSE -> select wins: EDIT entered with menu_index unchanged at 0.

Source files
------------

// File: rtl/timing_menu_controller.sv
// -----------------------------------------------------------------------------
// timing_menu_controller
//
// Button-driven configuration front end for the traffic light FSM. Four raw
// push-buttons are synchronized and debounced, then drive a two-state
// browse/edit menu. Edits go into a shadow register. A commit copies the
// shadow into the selected timing output in one step, so the light FSM never
// sees a partially edited value.
//
// Optional build macro: AUTO_REPEAT_EN
//   When it is defined, holding up or down in EDIT auto-repeats the step.
//   When it is undefined, only press pulses change the shadow.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   btn_up           raw button, increment
//   btn_down         raw button, decrement
//   btn_next         raw button, next field (BROWSE) / cancel (EDIT)
//   btn_select       raw button, enter edit (BROWSE) / commit (EDIT)
//   green_duration   committed green time, seconds
//   yellow_duration  committed yellow time, seconds
//   red_holding      committed all-red time, seconds
//   menu_index       selected field: 0=green, 1=yellow, 2=red
//   edit_active      high while in EDIT
//   edit_value       shadow value in EDIT, committed value of the field otherwise
//   config_changed   one-cycle pulse on commit
// -----------------------------------------------------------------------------
module timing_menu_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1_000_000_000,
  parameter logic [7:0]  GREEN_RST       = 8'd5,
  parameter logic [7:0]  YELLOW_RST      = 8'd2,
  parameter logic [7:0]  RED_RST         = 8'd1,
  parameter logic [7:0]  GREEN_MIN       = 8'd1,
  parameter logic [7:0]  GREEN_MAX       = 8'd99,
  parameter logic [7:0]  YELLOW_MIN      = 8'd1,
  parameter logic [7:0]  YELLOW_MAX      = 8'd9,
  parameter logic [7:0]  RED_MIN         = 8'd0,
  parameter logic [7:0]  RED_MAX         = 8'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_select,
  output logic [7:0] green_duration,
  output logic [7:0] yellow_duration,
  output logic [7:0] red_holding,
  output logic [1:0] menu_index,
  output logic       edit_active,
  output logic [7:0] edit_value,
  output logic       config_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [0:0] ST_BROWSE = 1'b0;
  localparam logic [0:0] ST_EDIT   = 1'b1;

  // Button index map: 0=up, 1=down, 2=next, 3=select.
  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_NX  = 2;
  localparam int B_SL  = 3;

  logic [3:0]    raw;
  logic [3:0]    sync1, sync2;
  logic [3:0]    level;
  logic [3:0]    press;
  logic [CW-1:0] db_cnt [4];

  assign raw = {btn_select, btn_next, btn_down, btn_up};

  // ---------------------------------------------------------------------------
  // Input conditioning. Each button has a 2-FF synchronizer. A counter then
  // measures how long the synchronized value has disagreed with the
  // debounced level. Once the counter has seen DEBOUNCE_CYCLES differing
  // cycles, the next differing cycle flips the level. A rising flip raises
  // press for exactly one cycle.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop in
  // this block samples values from before the edge. This is what makes
  // sync1 -> sync2 a real two-stage synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      // NOTE: the small counter array is reset on purpose. These are a few
      // flops and not a RAM, and a clean start keeps the first press latency
      // deterministic.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
          level[i]  <= sync2[i];
          press[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [0:0] state;
  logic [7:0] shadow;
  logic [31:0] idle_cnt;
  logic       step_up, step_down;

`ifdef AUTO_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat. It runs only while exactly one of up/down is held in EDIT.
  // A fresh press pulse restarts the delay. The first step comes after
  // REPEAT_DELAY cycles, and later steps come every REPEAT_RATE cycles.
  // ---------------------------------------------------------------------------
  localparam int unsigned REPEAT_DELAY = 50_000_000;
  localparam int unsigned REPEAT_RATE  = 10_000_000;

  logic [31:0] rep_cnt;
  logic        rep_first;
  logic        hold_one;
  logic [31:0] rep_limit;
  logic        rep_fire;

  assign hold_one  = (state == ST_EDIT) && (level[B_UP] ^ level[B_DN]);
  assign rep_limit = rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);
  assign rep_fire  = hold_one && !press[B_UP] && !press[B_DN] && (rep_cnt == rep_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (!hold_one || press[B_UP] || press[B_DN]) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_cnt == rep_limit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end

  assign step_up   = press[B_UP] | (rep_fire & level[B_UP]);
  assign step_down = press[B_DN] | (rep_fire & level[B_DN]);
`else
  assign step_up   = press[B_UP];
  assign step_down = press[B_DN];
`endif

  // ---------------------------------------------------------------------------
  // Menu FSM. Next-state logic is combinational. Every output is then loaded
  // from its next value, so the outputs come straight from flops.
  // ---------------------------------------------------------------------------
  logic [0:0]  state_n;
  logic [1:0]  menu_n;
  logic [7:0]  shadow_n, green_n, yellow_n, red_n, edit_value_n;
  logic [31:0] idle_n;
  logic        cfg_n;
  logic        acc_sel, acc_next, acc_up, acc_down, any_acc;
  logic [7:0]  cur_val, fmin, fmax, view_val;

  // Fixed priority: select > next > up > down. Losing pulses are dropped.
  assign acc_sel  = press[B_SL];
  assign acc_next = !press[B_SL] && press[B_NX];
  assign acc_up   = !press[B_SL] && !press[B_NX] && step_up;
  assign acc_down = !press[B_SL] && !press[B_NX] && !step_up && step_down;
  assign any_acc  = acc_sel | acc_next | acc_up | acc_down;

  // NOTE: every signal assigned in this block gets a default first. Without
  // that, some case branch would leave a signal unassigned and a latch would
  // be inferred.
  always_comb begin
    cur_val = green_duration;
    fmin    = GREEN_MIN;
    fmax    = GREEN_MAX;
    case (menu_index)
      2'd1: begin cur_val = yellow_duration; fmin = YELLOW_MIN; fmax = YELLOW_MAX; end
      2'd2: begin cur_val = red_holding;     fmin = RED_MIN;    fmax = RED_MAX;    end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    menu_n   = menu_index;
    shadow_n = shadow;
    green_n  = green_duration;
    yellow_n = yellow_duration;
    red_n    = red_holding;
    idle_n   = idle_cnt;
    cfg_n    = 1'b0;
    case (state)
      ST_BROWSE: begin
        idle_n = '0;
        if (acc_sel) begin
          shadow_n = cur_val;
          state_n  = ST_EDIT;
        end else if (acc_next) begin
          menu_n = (menu_index == 2'd2) ? 2'd0 : menu_index + 2'd1;
        end
      end
      default: begin
        if (any_acc) begin
          idle_n = '0;
        end else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
          idle_n  = '0;
          state_n = ST_BROWSE;
        end else begin
          idle_n = idle_cnt + 32'd1;
        end
        if (acc_sel) begin
          case (menu_index)
            2'd1:    yellow_n = shadow;
            2'd2:    red_n    = shadow;
            default: green_n  = shadow;
          endcase
          cfg_n   = 1'b1;
          state_n = ST_BROWSE;
        end else if (acc_next) begin
          state_n = ST_BROWSE;
        end else if (acc_up) begin
          shadow_n = (shadow >= fmax) ? fmax : shadow + 8'd1;
        end else if (acc_down) begin
          shadow_n = (shadow <= fmin) ? fmin : shadow - 8'd1;
        end
      end
    endcase

    // Display value as it will look after this edge.
    case (menu_n)
      2'd1:    view_val = yellow_n;
      2'd2:    view_val = red_n;
      default: view_val = green_n;
    endcase
    edit_value_n = (state_n == ST_EDIT) ? shadow_n : view_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_BROWSE;
      menu_index      <= 2'd0;
      shadow          <= 8'd0;
      idle_cnt        <= '0;
      green_duration  <= GREEN_RST;
      yellow_duration <= YELLOW_RST;
      red_holding     <= RED_RST;
      edit_active     <= 1'b0;
      edit_value      <= GREEN_RST;
      config_changed  <= 1'b0;
    end else begin
      state           <= state_n;
      menu_index      <= menu_n;
      shadow          <= shadow_n;
      idle_cnt        <= idle_n;
      green_duration  <= green_n;
      yellow_duration <= yellow_n;
      red_holding     <= red_n;
      edit_active     <= (state_n == ST_EDIT);
      edit_value      <= edit_value_n;
      config_changed  <= cfg_n;
    end
  end

endmodule

// File: tb/tb_timing_menu_controller.sv
// -----------------------------------------------------------------------------
// tb_timing_menu_controller
//
// Directed, table-driven bench for timing_menu_controller. It uses
// DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100. Each table row presses one button
// combination, releases it, and then compares the settled outputs with
// hand-computed values. Hand-written sequences cover reset, bounce/latency,
// the edit timeout, and the asynchronous reset during an edit.
// -----------------------------------------------------------------------------
module tb_timing_menu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_next, btn_select;
  logic [7:0] green_duration, yellow_duration, red_holding, edit_value;
  logic [1:0] menu_index;
  logic       edit_active, config_changed;

  timing_menu_controller #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_next       (btn_next),
    .btn_select     (btn_select),
    .green_duration (green_duration),
    .yellow_duration(yellow_duration),
    .red_holding    (red_holding),
    .menu_index     (menu_index),
    .edit_active    (edit_active),
    .edit_value     (edit_value),
    .config_changed (config_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cc_cnt = 0;
  int up_pulses = 0;

  always @(negedge clk) begin
    if (config_changed) cc_cnt++;
    if (dut.press[0]) up_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] btn;   // {select, next, down, up}
    logic [7:0] g, y, r;
    logic [1:0] menu;
    logic       ea;
    logic [7:0] ev;
    int         cc;    // config_changed pulses expected during this row
  } vec_t;

  vec_t vq[$];

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, NX = 4'b0100, SL = 4'b1000;

  function automatic vec_t mk(logic [3:0] b, logic [7:0] g, logic [7:0] y, logic [7:0] r,
                              logic [1:0] m, logic ea, logic [7:0] ev, int cc);
    vec_t v;
    v.btn = b; v.g = g; v.y = y; v.r = r; v.menu = m; v.ea = ea; v.ev = ev; v.cc = cc;
    return v;
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {btn_select, btn_next, btn_down, btn_up} = b;
  endtask

  task automatic run_rows(input int lo, input int hi);
    int cc0;
    for (int i = lo; i <= hi; i++) begin
      cc0 = cc_cnt;
      @(negedge clk);
      set_btn(vq[i].btn);
      repeat (10) @(negedge clk);
      set_btn(4'b0000);
      repeat (10) @(negedge clk);
      check($sformatf("row%0d green", i),  green_duration,  vq[i].g);
      check($sformatf("row%0d yellow", i), yellow_duration, vq[i].y);
      check($sformatf("row%0d red", i),    red_holding,     vq[i].r);
      check($sformatf("row%0d menu", i),   menu_index,      vq[i].menu);
      check($sformatf("row%0d edit", i),   edit_active,     vq[i].ea);
      check($sformatf("row%0d value", i),  edit_value,      vq[i].ev);
      check($sformatf("row%0d cc", i),     cc_cnt - cc0,    vq[i].cc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_k;
    // Green edit and commit.
    vq.push_back(mk(SL, 5, 2, 1, 0, 1, 5, 0));   // 0
    vq.push_back(mk(UP, 5, 2, 1, 0, 1, 6, 0));
    vq.push_back(mk(UP, 5, 2, 1, 0, 1, 7, 0));
    vq.push_back(mk(UP, 5, 2, 1, 0, 1, 8, 0));
    vq.push_back(mk(SL, 8, 2, 1, 0, 0, 8, 1));
    // Red edit, saturation at 0, then cancel.
    vq.push_back(mk(NX, 8, 2, 1, 1, 0, 2, 0));   // 5
    vq.push_back(mk(NX, 8, 2, 1, 2, 0, 1, 0));
    vq.push_back(mk(SL, 8, 2, 1, 2, 1, 1, 0));
    vq.push_back(mk(DN, 8, 2, 1, 2, 1, 0, 0));
    vq.push_back(mk(DN, 8, 2, 1, 2, 1, 0, 0));
    vq.push_back(mk(DN, 8, 2, 1, 2, 1, 0, 0));   // 10
    vq.push_back(mk(NX, 8, 2, 1, 2, 0, 1, 0));
    // Up is ignored in BROWSE. Then edit yellow up to its max.
    vq.push_back(mk(NX, 8, 2, 1, 0, 0, 8, 0));
    vq.push_back(mk(UP, 8, 2, 1, 0, 0, 8, 0));
    vq.push_back(mk(NX, 8, 2, 1, 1, 0, 2, 0));
    vq.push_back(mk(SL, 8, 2, 1, 1, 1, 2, 0));   // 15
    for (int k = 3; k <= 12; k++)
      vq.push_back(mk(UP, 8, 2, 1, 1, 1, (k > 9) ? 8'd9 : 8'(k), 0));  // 16..25
    // After the timeout: select and next pressed together, then cancel.
    vq.push_back(mk(NX, 8, 2, 1, 2, 0, 1, 0));   // 26
    vq.push_back(mk(NX, 8, 2, 1, 0, 0, 8, 0));
    vq.push_back(mk(SL | NX, 8, 2, 1, 0, 1, 8, 0));
    vq.push_back(mk(DN, 8, 2, 1, 0, 1, 7, 0));
    vq.push_back(mk(NX, 8, 2, 1, 0, 0, 8, 0));   // 30
    vq.push_back(mk(NX, 8, 2, 1, 1, 0, 2, 0));
    vq.push_back(mk(SL, 8, 2, 1, 1, 1, 2, 0));   // 32

    // Reset values.
    set_btn(4'b0000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst green",  green_duration,  8'd5);
    check("rst yellow", yellow_duration, 8'd2);
    check("rst red",    red_holding,     8'd1);
    check("rst menu",   menu_index,      2'd0);
    check("rst edit",   edit_active,     1'b0);
    check("rst cc",     config_changed,  1'b0);

    // Bounce 1-0-1 and then hold. Expect one pulse, 6 edges after the final
    // rising level is sampled.
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    btn_up = 1'b1;
    first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dut.press[0] && first_k < 0) first_k = k;
    end
    check("bounce pulse count", up_pulses, 1);
    check("bounce latency", first_k, 7);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    check("release no pulse", up_pulses, 1);
    check("browse up ignored", green_duration, 8'd5);

    run_rows(0, 25);

    // Idle in yellow EDIT. About 12 idle cycles have passed here. The cancel
    // comes at 100 idle cycles.
    repeat (60) @(negedge clk);
    check("timeout not yet", edit_active, 1'b1);
    begin
      int cc0;
      cc0 = cc_cnt;
      repeat (40) @(negedge clk);
      check("timeout edit", edit_active, 1'b0);
      check("timeout yellow", yellow_duration, 8'd2);
      check("timeout value", edit_value, 8'd2);
      check("timeout menu", menu_index, 2'd1);
      check("timeout cc", cc_cnt - cc0, 0);
    end

    run_rows(26, 32);

    // Assert reset away from any clock edge, in the middle of a yellow edit.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async green", green_duration, 8'd5);
    check("async yellow", yellow_duration, 8'd2);
    check("async red", red_holding, 8'd1);
    check("async menu", menu_index, 2'd0);
    check("async edit", edit_active, 1'b0);
    check("async value", edit_value, 8'd5);
    check("async cc", config_changed, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst edit", edit_active, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
